// File: rtl/nios_boot_stream_loader.sv
// Boot loader for the Nios II on-chip program memory: receives a framed byte stream
// (LEN, payload, CSUM), writes packed little-endian words from address 0, then hands the port to the CPU.
module nios_boot_stream_loader #(
  parameter int DEPTH  = 32000,
  parameter int ADDR_W = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        s_data,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [ADDR_W-1:0] cpu_address,
  input  logic [3:0]        cpu_byteenable,
  input  logic              cpu_chipselect,
  input  logic              cpu_write,
  input  logic [31:0]       cpu_writedata,
  input  logic              cpu_clken,
  output logic [ADDR_W-1:0] mem_address,
  output logic [3:0]        mem_byteenable,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [31:0]       mem_writedata,
  output logic              mem_clken,
  output logic              cpu_reset,
  output logic              done,
  output logic              error,
  output logic [ADDR_W-1:0] words_loaded
);

  typedef enum logic [2:0] {
    HDR  = 3'd0,
    CHK  = 3'd1,
    DATA = 3'd2,
    SUMC = 3'd3,
    DONE = 3'd4,
    ERR  = 3'd5
  } state_t;

  localparam logic [31:0] DEPTH_W = 32'(DEPTH);

  state_t              state_q, state_d;
  logic [1:0]          cnt_q, cnt_d;
  logic [31:0]         asm_q, asm_d;
  logic [31:0]         len_q, len_d;
  logic [31:0]         sum_q, sum_d;
  logic [ADDR_W-1:0]   words_q, words_d;
  logic                wr_q, wr_d;
  logic [ADDR_W-1:0]   waddr_q, waddr_d;
  logic [31:0]         wdata_q, wdata_d;

  logic                accept_s;
  logic [31:0]         word_s;
  logic [ADDR_W-1:0]   words_inc_s;
  logic                done_s;

  assign s_ready     = (state_q == HDR) || (state_q == DATA) || (state_q == SUMC);
  assign accept_s    = s_valid & s_ready;
  // Bytes shift in at the top, so after four accepts byte 0 sits in [7:0].
  assign word_s      = {s_data, asm_q[31:8]};
  assign words_inc_s = words_q + {{(ADDR_W-1){1'b0}}, 1'b1};
  assign done_s      = (state_q == DONE);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    asm_d   = asm_q;
    len_d   = len_q;
    sum_d   = sum_q;
    words_d = words_q;
    wr_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    if (accept_s) begin
      asm_d = word_s;
      cnt_d = cnt_q + 2'd1;
    end else begin
      cnt_d = cnt_q;
    end
    case (state_q)
      HDR: begin
        if (accept_s && (cnt_q == 2'd3)) begin
          len_d   = word_s;
          state_d = CHK;
        end else begin
          state_d = HDR;
        end
      end
      CHK: begin
        if (len_q > DEPTH_W) begin
          state_d = ERR;
        end else if (len_q == 32'd0) begin
          state_d = SUMC;
        end else begin
          state_d = DATA;
        end
      end
      DATA: begin
        if (accept_s && (cnt_q == 2'd3)) begin
          wr_d    = 1'b1;
          waddr_d = words_q;
          wdata_d = word_s;
          words_d = words_inc_s;
          sum_d   = sum_q + word_s;
          // LEN was bounded by DEPTH in CHK, so the zero-extended count compare is exact.
          if ({{(32-ADDR_W){1'b0}}, words_inc_s} == len_q) begin
            state_d = SUMC;
          end else begin
            state_d = DATA;
          end
        end else begin
          state_d = DATA;
        end
      end
      SUMC: begin
        if (accept_s && (cnt_q == 2'd3)) begin
          state_d = (word_s == sum_q) ? DONE : ERR;
        end else begin
          state_d = SUMC;
        end
      end
      DONE:    state_d = DONE;
      ERR:     state_d = ERR;
      default: state_d = ERR;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= HDR;
      cnt_q   <= 2'd0;
      asm_q   <= 32'd0;
      len_q   <= 32'd0;
      sum_q   <= 32'd0;
      words_q <= {ADDR_W{1'b0}};
      wr_q    <= 1'b0;
      waddr_q <= {ADDR_W{1'b0}};
      wdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      asm_q   <= asm_d;
      len_q   <= len_d;
      sum_q   <= sum_d;
      words_q <= words_d;
      wr_q    <= wr_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
    end
  end

  assign done         = done_s;
  assign error        = (state_q == ERR);
  assign cpu_reset    = ~done_s;
  assign words_loaded = words_q;

  // Once verified, the memory port is a pure combinational pass-through of the CPU side.
  assign mem_address    = done_s ? cpu_address    : waddr_q;
  assign mem_byteenable = done_s ? cpu_byteenable : 4'hF;
  assign mem_chipselect = done_s ? cpu_chipselect : wr_q;
  assign mem_write      = done_s ? cpu_write      : wr_q;
  assign mem_writedata  = done_s ? cpu_writedata  : wdata_q;
  assign mem_clken      = done_s ? cpu_clken      : 1'b1;

endmodule
